// File: rtl/seq_shift_reg_if.sv
// Request/response bundle for seq_shift_reg: command inputs plus register and handshake outputs.
// The zero/ovf status signals exist only when SEQ_SHIFT_STATUS_EN is defined.
interface seq_shift_reg_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
);
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic [AMT_W-1:0] amt;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             sout;
`ifdef SEQ_SHIFT_STATUS_EN
    logic             zero;
    logic             ovf;

    modport master (
        output start, mode, d, amt, sin,
        input  q, busy, done, sout, zero, ovf
    );

    modport slave (
        input  start, mode, d, amt, sin,
        output q, busy, done, sout, zero, ovf
    );
`else
    modport master (
        output start, mode, d, amt, sin,
        input  q, busy, done, sout
    );

    modport slave (
        input  start, mode, d, amt, sin,
        output q, busy, done, sout
    );
`endif
endinterface

// File: rtl/seq_shift_reg.sv
// WIDTH-bit load/clear/shift/rotate register; multi-position shifts run one step per clock.
// Define SEQ_SHIFT_STATUS_EN to add the registered zero flag and sticky ovf flag.
module seq_shift_reg #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    seq_shift_reg_if.slave bus
);
    typedef enum logic [2:0] {
        M_NOP  = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_SAR  = 3'b100,
        M_ROL  = 3'b101,
        M_ROR  = 3'b110,
        M_CLR  = 3'b111
    } mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    mode_t            op_r, op_n, req_mode;
    logic [WIDTH-1:0] q_r, q_n, step_q;
    logic [AMT_W-1:0] cnt_r, cnt_n;
    logic             done_r, done_n;
    logic             sout_r, sout_n;
    logic             step_out;
    logic             req_shift;
`ifdef SEQ_SHIFT_STATUS_EN
    logic             zero_r;
    logic             ovf_r, ovf_n;
`endif

    assign req_mode  = mode_t'(bus.mode);
    assign req_shift = req_mode inside {M_SHL, M_SHR, M_SAR, M_ROL, M_ROR};

    // One position of the captured operation; sin is taken live on every step.
    always_comb begin
        step_q   = q_r;
        step_out = sout_r;
        case (op_r)
            M_SHL: begin
                step_q   = {q_r[WIDTH-2:0], bus.sin};
                step_out = q_r[WIDTH-1];
            end
            M_SHR: begin
                step_q   = {bus.sin, q_r[WIDTH-1:1]};
                step_out = q_r[0];
            end
            M_SAR: begin
                step_q   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                step_out = q_r[0];
            end
            M_ROL: begin
                step_q   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                step_out = q_r[WIDTH-1];
            end
            M_ROR: begin
                step_q   = {q_r[0], q_r[WIDTH-1:1]};
                step_out = q_r[0];
            end
            default: begin
                step_q   = q_r;
                step_out = sout_r;
            end
        endcase
    end

    always_comb begin
        state_n = state;
        op_n    = op_r;
        q_n     = q_r;
        cnt_n   = cnt_r;
        done_n  = 1'b0;
        sout_n  = sout_r;
`ifdef SEQ_SHIFT_STATUS_EN
        ovf_n   = ovf_r;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef SEQ_SHIFT_STATUS_EN
                    ovf_n = 1'b0;
`endif
                    if (req_shift && (bus.amt != '0)) begin
                        state_n = SHIFT;
                        op_n    = req_mode;
                        cnt_n   = bus.amt;
                    end else begin
                        done_n = 1'b1;
                        case (req_mode)
                            M_LOAD:  q_n = bus.d;
                            M_CLR:   q_n = '0;
                            default: q_n = q_r;
                        endcase
                    end
                end
            end
            SHIFT: begin
                q_n    = step_q;
                sout_n = step_out;
                cnt_n  = cnt_r - 1'b1;
`ifdef SEQ_SHIFT_STATUS_EN
                if ((op_r == M_SHL || op_r == M_SAR) && (step_out != step_q[WIDTH-1]))
                    ovf_n = 1'b1;
`endif
                if (cnt_r == AMT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_r   <= M_NOP;
            q_r    <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
            sout_r <= 1'b0;
`ifdef SEQ_SHIFT_STATUS_EN
            zero_r <= 1'b1;
            ovf_r  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            op_r   <= op_n;
            q_r    <= q_n;
            cnt_r  <= cnt_n;
            done_r <= done_n;
            sout_r <= sout_n;
`ifdef SEQ_SHIFT_STATUS_EN
            zero_r <= (q_n == '0);
            ovf_r  <= ovf_n;
`endif
        end
    end

    assign bus.q    = q_r;
    assign bus.busy = (state == SHIFT);
    assign bus.done = done_r;
    assign bus.sout = sout_r;
`ifdef SEQ_SHIFT_STATUS_EN
    assign bus.zero = zero_r;
    assign bus.ovf  = ovf_r;
`endif
endmodule

// File: tb/tb_seq_shift_reg.sv
// Scoreboard bench for seq_shift_reg: the driver pushes expected results from a closed-form
// model, and a negedge monitor pops and checks them on every done pulse.
module tb_seq_shift_reg;
    localparam int W  = 4;
    localparam int AW = 3;
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_shift_reg_if #(.WIDTH(W), .AMT_W(AW)) bus ();
    seq_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [W-1:0] q;
        logic         sout;
        int           nbusy;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] mq       = '0;
    logic         msout    = 1'b0;
    int           bcount   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] fill(input logic s);
        return s ? MASK : 64'd0;
    endfunction

    // Value after k positions of mode m starting from v, with constant fill bit s.
    function automatic logic [W-1:0] after(input logic [2:0] m, input logic [W-1:0] v,
                                           input int k, input logic s);
        logic [63:0] x;
        int r;
        x = 64'(v);
        r = k % W;
        case (m)
            3'b010: x = (k >= W) ? fill(s) : (((x << k) | (fill(s) >> (W - k))) & MASK);
            3'b011: x = (k >= W) ? fill(s) : (((x >> k) | (fill(s) & ~(MASK >> k))) & MASK);
            3'b100: x = (k >= W) ? fill(v[W-1])
                                 : (((x >> k) | (fill(v[W-1]) & ~(MASK >> k))) & MASK);
            3'b101: x = ((x << r) | (x >> (W - r))) & MASK;
            3'b110: x = ((x >> r) | (x << (W - r))) & MASK;
            default: x = 64'(v);
        endcase
        return x[W-1:0];
    endfunction

    function automatic exp_t model(input logic [2:0] m, input logic [W-1:0] d,
                                   input logic [AW-1:0] amt, input logic s);
        exp_t e;
        logic [W-1:0] prev, cur;
        logic ob;
        int n;
        n = int'(amt);
        e.nbusy = 0;
        e.ovf   = 1'b0;
        e.sout  = msout;
        if (m inside {3'b000, 3'b001, 3'b111} || n == 0) begin
            e.q = (m == 3'b001) ? d : (m == 3'b111) ? '0 : mq;
        end else begin
            e.nbusy = n;
            e.q     = after(m, mq, n, s);
            prev    = after(m, mq, n - 1, s);
            case (m)
                3'b010:  e.sout = prev[W-1];
                3'b101:  e.sout = e.q[0];
                3'b110:  e.sout = e.q[W-1];
                default: e.sout = prev[0];
            endcase
            if (m == 3'b010 || m == 3'b100) begin
                for (int k = 1; k <= n; k++) begin
                    prev = after(m, mq, k - 1, s);
                    cur  = after(m, mq, k, s);
                    ob   = (m == 3'b010) ? prev[W-1] : prev[0];
                    if (ob != cur[W-1]) e.ovf = 1'b1;
                end
            end
        end
        e.zero = (e.q == '0);
        return e;
    endfunction

    // junk: 0 quiet, 1 random inputs while busy, 2 start pulses with CLR while busy
    task automatic do_op(input logic [2:0] m, input logic [W-1:0] d,
                         input logic [AW-1:0] amt, input logic s, input int junk);
        exp_t e;
        int guard;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.d     = d;
        bus.amt   = amt;
        bus.sin   = s;
        e = model(m, d, amt, s);
        sb.push_back(e);
        mq    = e.q;
        msout = e.sout;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (bus.done !== 1'b1 && guard < 20) begin
            if (junk == 1) begin
                bus.start = 1'($urandom);
                bus.mode  = 3'($urandom);
                bus.d     = W'($urandom);
                bus.amt   = AW'($urandom);
            end else if (junk == 2) begin
                bus.start = ~bus.start;
                bus.mode  = 3'b111;
            end
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("q_at_done", 64'(bus.q), 64'(e.q));
                chk("sout_at_done", 64'(bus.sout), 64'(e.sout));
                chk("busy_cycles", 64'(bcount), 64'(e.nbusy));
                chk("busy_with_done", 64'(bus.busy), 64'd0);
`ifdef SEQ_SHIFT_STATUS_EN
                chk("zero_at_done", 64'(bus.zero), 64'(e.zero));
                chk("ovf_at_done", 64'(bus.ovf), 64'(e.ovf));
`endif
            end
            bcount = 0;
        end else if (bus.busy === 1'b1) begin
            bcount++;
        end else begin
            bcount = 0;
        end
    end

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_q"}, 64'(bus.q), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_sout"}, 64'(bus.sout), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.mode  = 3'b001;
        bus.d     = 4'b1111;
        bus.amt   = '0;
        bus.sin   = 1'b0;
        @(negedge clk);
        chk_idle_zero("rst1");
        @(negedge clk);
        chk_idle_zero("rst2");
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk_idle_zero("rst_rel");
`ifdef SEQ_SHIFT_STATUS_EN
        chk("rst_zero", 64'(bus.zero), 64'd1);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        mq = '0;
        msout = 1'b0;

        do_op(3'b001, 4'b1011, 3'd0, 1'b0, 0);
        do_op(3'b101, 4'b0000, 3'd3, 1'b0, 0);
        do_op(3'b001, 4'b1000, 3'd0, 1'b0, 0);
        do_op(3'b100, 4'b0000, 3'd2, 1'b0, 0);
        do_op(3'b001, 4'b0001, 3'd0, 1'b0, 0);
        do_op(3'b010, 4'b0000, 3'd5, 1'b0, 0);
        do_op(3'b001, 4'b1001, 3'd0, 1'b0, 0);
        do_op(3'b110, 4'b0000, 3'd3, 1'b0, 2);
        do_op(3'b011, 4'b0000, 3'd0, 1'b1, 0);
        do_op(3'b011, 4'b0000, 3'd7, 1'b1, 0);
        do_op(3'b111, 4'b0101, 3'd0, 1'b0, 0);
        do_op(3'b000, 4'b1111, 3'd0, 1'b0, 0);

        do_op(3'b001, 4'b0110, 3'd0, 1'b0, 0);
        bus.start = 1'b1;
        bus.mode  = 3'b110;
        bus.amt   = 3'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero("abort");
        @(negedge clk);
        chk("abort_no_done", 64'(bus.done), 64'd0);
        mq = '0;
        msout = 1'b0;

        for (int i = 0; i < 80; i++) begin
            logic [2:0] m;
            m = 3'($urandom);
            if (m inside {3'b010, 3'b011, 3'b100, 3'b101, 3'b110} && ($urandom % 3 != 0))
                do_op(m, W'($urandom), AW'($urandom_range(0, 7)), 1'($urandom), 1);
            else
                do_op(m, W'($urandom), AW'($urandom_range(0, 2)), 1'($urandom), 1);
            if ($urandom % 4 == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
